ladybird_uart_tx_fifo: RTL
==========================

Name: ladybird_uart_tx_fifo

Overview:
Configurable UART transmitter with an input FIFO, replacing the fixed 8N1, fixed-baud transmitter.
- Per-frame runtime config: data length 5–8, parity none/even/odd, 1 or 2 stop bits, 16-bit baud divisor.
- Sits between the core's MMIO/console path and the TX pin; accepts bytes via valid/ready and serialises them back-to-back.

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- DEFAULT_DIV, 16'h28B0: informational reset value recommended for the divisor register in the parent block; not used inside this module.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- valid  input  1  byte offered
- data  input  8  byte; bits above the configured length are ignored
- ready  output  1  FIFO can accept; equals !full
- cfg_div  input  16  bit period minus one, in clk cycles
- cfg_bits  input  2  data length: 00=5, 01=6, 10=7, 11=8
- cfg_par  input  2  parity: 00/11=none, 01=even, 10=odd
- cfg_stop2  input  1  0=one stop bit, 1=two stop bits
- tx  output  1  serial line, registered, idle high
- busy  output  1  frame in progress
- level  output  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rst=1 at posedge):
  - tx=1, busy=0, level=0, ready=1.
  - FIFO pointers cleared; state IDLE; bit counter and baud counter cleared.
  - Reset mid-frame aborts immediately: tx=1 on the next cycle, queued bytes are discarded.
- Handshake:
  - Push when valid&ready at a posedge.
  - ready is combinational from level only, never from valid.
  - Full FIFO ⇒ ready=0 and data is not captured.
  - Push and pop in the same cycle ⇒ level unchanged.
- Frame state machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if level≠0, pop at this edge, latch byte and all cfg_* into shadow registers, go to START, baud counter=cfg_div.
  - cfg_* changes during a frame have no effect until the next pop.
  - Each state holds tx for exactly shadow_div+1 cycles; baud counter decrements, and the state advances when it is 0.
  - cfg_div=0 ⇒ 1 cycle per bit.
  - START: tx=0.
  - DATA: bits sent LSB first; bit index counts 0..N-1 (N=5..8).
  - PARITY: present only if parity is enabled. Value = XOR of the N sent bits for even, inverted for odd.
  - STOP: tx=1 for 1 or 2 bit periods.
- Back-to-back: on the last cycle of the final stop bit, if level≠0, pop at that edge and go directly to START; no idle gap. Otherwise go to IDLE.
- Latency: byte pushed at edge E0 into an empty FIFO with the engine idle ⇒ popped at E1; tx=0 from E1.
- busy=1 from the pop edge through the last stop cycle; busy=0 in IDLE.
- Frame length in cycles = (shadow_div+1) × (1 + N + P + S), where P∈{0,1} and S∈{1,2}.
- FIFO: circular, pointers wrap modulo DEPTH. level is exact; full when level==DEPTH.

Test Plan:
- Reset, then cfg_div=3, 8N1; push 0x55 ⇒ tx low 1 cycle after the accept edge. tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; busy for 40 cycles, then tx=1 and busy=0.
- cfg_bits=10 (7 data bits), even parity, cfg_stop2=1, cfg_div=1; push 0x87 ⇒ bits 0,1,1,1,0,0,0,0, parity 1, stop 1,1. 11 bits × 2 cycles; bit 7 of data ignored.
- DEPTH=4, cfg_div=9; valid held high with 6 distinct bytes ⇒ 5 accepted (1 popped immediately, 4 queued), ready=0 while level=4. Bytes emitted in order with no idle cycle between frames.
- Mid-frame cfg change: start 0x0F at 8N1, switch to odd parity and cfg_div=0 during DATA ⇒ current frame unchanged. Next queued byte 0x01 uses odd parity (parity bit 0) at 1 cycle per bit.
- Assert rst during DATA of the second of 3 queued bytes ⇒ next cycle tx=1, busy=0, level=0, ready=1; no further frames emitted.
- Push while popping with level=2 ⇒ level stays 2. After draining, level returns to 0 and wraps correctly over 3×DEPTH bytes.

Source files
------------

// File: rtl/ladybird_uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Frame format (5-8 data bits, parity, 1/2 stop bits, baud divisor) is sampled per frame at pop time.
module ladybird_uart_tx_fifo #(
  parameter int DEPTH       = 4,
  parameter     DEFAULT_DIV = 16'h28B0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [7:0]               data,
  output logic                     ready,
  input  logic [15:0]              cfg_div,
  input  logic [1:0]               cfg_bits,
  input  logic [1:0]               cfg_par,
  input  logic                     cfg_stop2,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // DEFAULT_DIV is only a reset value for the parent's divisor register; its width must match cfg_div.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || $bits(DEFAULT_DIV) != 16) begin : g_bad_param
    $error("ladybird_uart_tx_fifo: DEPTH must be a power of two >= 2 and DEFAULT_DIV 16 bits wide");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign ready = (level != LW'(DEPTH));
  assign push  = valid && ready;

  // NOTE: the storage array has no reset; only pointers and level carry state that matters after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  // Pointers are AW bits wide, so increments wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------- frame engine
  state_t      state;
  logic [15:0] baud_cnt;
  logic [15:0] sh_div;
  logic [7:0]  sh_data;
  logic [2:0]  sh_last;
  logic        sh_par_en;
  logic        sh_par_bit;
  logic        sh_stop2;
  logic [2:0]  bit_idx;
  logic        stop_idx;

  logic        bit_done;
  logic        last_stop;
  logic [7:0]  head_mask;
  logic [7:0]  head_data;
  logic [2:0]  cfg_last;

  assign bit_done  = (baud_cnt == '0);
  assign last_stop = (state == S_STOP) && bit_done && (!sh_stop2 || stop_idx);
  // A pop happens either from idle or on the final stop cycle, giving gap-free back-to-back frames.
  assign pop       = (level != '0) && ((state == S_IDLE) || last_stop);

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    head_mask = 8'hFF;
    case (cfg_bits)
      2'b00:   head_mask = 8'h1F;
      2'b01:   head_mask = 8'h3F;
      2'b10:   head_mask = 8'h7F;
      default: head_mask = 8'hFF;
    endcase
    head_data = mem[rd_ptr] & head_mask;
    cfg_last  = 3'd4 + {1'b0, cfg_bits};
  end

  // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tx         <= 1'b1;
      busy       <= 1'b0;
      baud_cnt   <= '0;
      sh_div     <= '0;
      sh_data    <= '0;
      sh_last    <= '0;
      sh_par_en  <= 1'b0;
      sh_par_bit <= 1'b0;
      sh_stop2   <= 1'b0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
    end else if (pop) begin
      state      <= S_START;
      tx         <= 1'b0;
      busy       <= 1'b1;
      baud_cnt   <= cfg_div;
      sh_div     <= cfg_div;
      sh_data    <= head_data;
      sh_last    <= cfg_last;
      sh_par_en  <= (cfg_par == 2'b01) || (cfg_par == 2'b10);
      sh_par_bit <= (^head_data) ^ (cfg_par == 2'b10);
      sh_stop2   <= cfg_stop2;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
    end else if (state != S_IDLE) begin
      if (!bit_done) begin
        baud_cnt <= baud_cnt - 1'b1;
      end else begin
        baud_cnt <= sh_div;
        case (state)
          S_START: begin
            state   <= S_DATA;
            tx      <= sh_data[0];
            bit_idx <= '0;
          end
          S_DATA: begin
            if (bit_idx == sh_last) begin
              if (sh_par_en) begin
                state <= S_PARITY;
                tx    <= sh_par_bit;
              end else begin
                state <= S_STOP;
                tx    <= 1'b1;
              end
            end else begin
              // The shadow byte shifts right so the next bit to send is always bit 0.
              bit_idx <= bit_idx + 1'b1;
              sh_data <= {1'b0, sh_data[7:1]};
              tx      <= sh_data[1];
            end
          end
          S_PARITY: begin
            state <= S_STOP;
            tx    <= 1'b1;
          end
          S_STOP: begin
            if (sh_stop2 && !stop_idx) begin
              stop_idx <= 1'b1;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
              tx    <= 1'b1;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
